// File: rtl/fc_input_packer_pkg.sv
// Shared constants and FSM encoding for the fully_connected input packer.
// WORD_WIDTH/INPUT_SIZE defaults here must match the fully_connected block.
package fc_input_packer_pkg;
    localparam int FC_WORD_WIDTH = 16;
    localparam int FC_INPUT_SIZE = 512;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } pack_state_t;
endpackage

// File: rtl/fc_input_packer.sv
// Packs a serial stream of WORD_WIDTH samples into one INPUT_SIZE vector for
// fully_connected; first sample lands in the MSB slice.
module fc_input_packer
    import fc_input_packer_pkg::*;
#(
    parameter int INPUT_SIZE = FC_INPUT_SIZE,
    parameter int WORD_WIDTH = FC_WORD_WIDTH,
    parameter int MIN_GAP    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [INPUT_SIZE-1:0] data_in,
    output logic                  data_valid,
    output logic                  err_short,
    output logic                  err_nolast
);
    localparam int NUM_WORDS = INPUT_SIZE / WORD_WIDTH;
    localparam int CW        = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int GW        = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NUM_WORDS - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((MIN_GAP > 0) ? MIN_GAP - 1 : 0);

    pack_state_t           r_state, w_next;
    logic [CW-1:0]         r_cnt;
    logic [GW-1:0]         r_gap;
    logic [INPUT_SIZE-1:0] r_buf, w_frame;
    logic                  w_xfer, w_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_FILL;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        in_ready = (r_state == ST_FILL);
        w_xfer   = in_valid & in_ready;
        w_end    = w_xfer & (in_last | (r_cnt == CNT_LAST));
        case (r_state)
            ST_FILL: if (w_end && MIN_GAP > 0) w_next = ST_HOLD;
            ST_HOLD: if (r_gap == GAP_LAST)    w_next = ST_FILL;
            default: w_next = ST_FILL;
        endcase
    end

    // Gap counter models the downstream compute time between frames.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    r_gap <= '0;
        else if (r_state == ST_HOLD) r_gap <= (r_gap == GAP_LAST) ? '0 : r_gap + 1'b1;
        else                        r_gap <= '0;
    end

    // Assembly buffer with the current sample merged in; emitted directly on
    // frame end so the final word needs no extra cycle.
    always_comb begin
        w_frame = r_buf;
        for (int k = 0; k < NUM_WORDS; k++) begin
            if (r_cnt == CW'(k))
                w_frame[INPUT_SIZE-1-k*WORD_WIDTH -: WORD_WIDTH] = in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_buf      <= '0;
            data_in    <= '0;
            data_valid <= 1'b0;
            err_short  <= 1'b0;
            err_nolast <= 1'b0;
        end else begin
            data_valid <= w_end;
            err_short  <= w_end & in_last & (r_cnt != CNT_LAST);
            err_nolast <= w_end & ~in_last;
            if (w_end) begin
                data_in <= w_frame;
                r_buf   <= '0;
                r_cnt   <= '0;
            end else if (w_xfer) begin
                r_buf <= w_frame;
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fc_input_packer.sv
// Directed bench for fc_input_packer: one instance with MIN_GAP=4, one with MIN_GAP=0.
module tb_fc_input_packer;
    localparam int IS = 512;
    localparam int WW = 16;

    logic clk = 1'b0;
    logic rst;
    logic [WW-1:0] d4, d0;
    logic v4, l4, v0, l0;
    logic rdy4, dv4, es4, en4, rdy0, dv0, es0, en0;
    logic [IS-1:0] di4, di0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n, t1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fc_input_packer #(.INPUT_SIZE(IS), .WORD_WIDTH(WW), .MIN_GAP(4)) u_g4 (
        .clk(clk), .rst(rst), .in_data(d4), .in_valid(v4), .in_last(l4),
        .in_ready(rdy4), .data_in(di4), .data_valid(dv4),
        .err_short(es4), .err_nolast(en4));

    fc_input_packer #(.INPUT_SIZE(IS), .WORD_WIDTH(WW), .MIN_GAP(0)) u_g0 (
        .clk(clk), .rst(rst), .in_data(d0), .in_valid(v0), .in_last(l0),
        .in_ready(rdy0), .data_in(di0), .data_valid(dv0),
        .err_short(es0), .err_nolast(en0));

    task automatic chk(input string tag, input logic [IS-1:0] obs, input logic [IS-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [IS-1:0] frame(input int base, input int step, input int nw);
        logic [IS-1:0] f;
        f = '0;
        for (int k = 0; k < nw; k++) f[IS-1-k*WW -: WW] = WW'(base + step * k);
        return f;
    endfunction

    task automatic send4(input int val, input logic last);
        v4 = 1'b1; d4 = WW'(val); l4 = last;
        @(posedge clk); #1;
    endtask

    task automatic wait_ready4();
        int m;
        m = 0;
        while (rdy4 !== 1'b1 && m < 20) begin
            m++;
            @(posedge clk); #1;
        end
        chk("ready_timeout", rdy4, 1);
    endtask

    initial begin
        rst = 1'b1;
        v4 = 0; d4 = '0; l4 = 0;
        v0 = 0; d0 = '0; l0 = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data_in", di4, 0);
        chk("rst_valid", dv4, 0);
        chk("rst_ready", rdy4, 1);
        chk("rst_err_short", es4, 0);
        chk("rst_err_nolast", en4, 0);
        chk("rst_ready_g0", rdy0, 1);
        rst = 1'b0;

        // Full frame 1..32 with last on the final word
        for (int k = 0; k < 32; k++) begin
            send4(k + 1, k == 31);
            if (k == 30) begin
                chk("no_early_strobe", dv4, 0);
                chk("data_in_held", di4, 0);
            end
        end
        chk("full_valid", dv4, 1);
        chk("full_data", di4, frame(1, 1, 32));
        chk("full_err_short", es4, 0);
        chk("full_err_nolast", en4, 0);
        chk("hold_ready_low", rdy4, 0);

        // in_valid held high through HOLD; sample 10 must start the next frame
        v4 = 1'b1; d4 = 16'd10; l4 = 1'b0;
        n = 0;
        while (rdy4 !== 1'b1 && n < 20) begin
            n++;
            @(posedge clk); #1;
        end
        chk("gap_cycles", n, 4);
        chk("strobe_one_cycle", dv4, 0);
        chk("hold_keeps_data", di4, frame(1, 1, 32));

        send4(10, 0); send4(20, 0); send4(30, 0); send4(40, 0); send4(50, 1);
        chk("short_valid", dv4, 1);
        chk("short_upper", IS'(di4[IS-1 -: 80]), IS'(80'h000a_0014_001e_0028_0032));
        chk("short_data", di4, frame(10, 10, 5));
        chk("short_err_short", es4, 1);
        chk("short_err_nolast", en4, 0);
        v4 = 1'b0;
        @(posedge clk); #1;
        chk("short_err_pulse", es4, 0);
        chk("short_valid_pulse", dv4, 0);

        // Full frame with no last
        wait_ready4();
        for (int k = 0; k < 32; k++) send4(100 + k, 0);
        chk("nolast_valid", dv4, 1);
        chk("nolast_data", di4, frame(100, 1, 32));
        chk("nolast_err_nolast", en4, 1);
        chk("nolast_err_short", es4, 0);
        v4 = 1'b0;
        @(posedge clk); #1;
        chk("nolast_err_pulse", en4, 0);
        wait_ready4();
        for (int k = 0; k < 32; k++) send4(200 + k, k == 31);
        chk("after_nolast_data", di4, frame(200, 1, 32));
        chk("after_nolast_errs", {es4, en4}, 0);

        // Reset mid-frame after 17 words
        v4 = 1'b0;
        wait_ready4();
        for (int k = 0; k < 17; k++) send4(400 + k, 0);
        v4 = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_data_in", di4, 0);
        chk("midrst_valid", dv4, 0);
        chk("midrst_ready", rdy4, 1);
        chk("midrst_errs", {es4, en4}, 0);
        @(posedge clk); #1;
        chk("midrst_no_strobe", dv4, 0);
        rst = 1'b0;
        for (int k = 0; k < 32; k++) send4(300 + k, k == 31);
        chk("post_rst_valid", dv4, 1);
        chk("post_rst_data", di4, frame(300, 1, 32));
        v4 = 1'b0;

        // MIN_GAP=0: back-to-back frames
        t1 = 0;
        for (int i = 0; i < 64; i++) begin
            v0 = 1'b1; d0 = WW'(10 * (i + 1)); l0 = (i == 31 || i == 63);
            @(posedge clk); #1;
            if (i == 31) begin
                chk("b2b_valid1", dv0, 1);
                chk("b2b_data1", di0, frame(10, 10, 32));
                chk("b2b_ready", rdy0, 1);
                t1 = cyc;
            end
            if (i == 32) chk("b2b_single_strobe", dv0, 0);
            if (i == 63) begin
                chk("b2b_valid2", dv0, 1);
                chk("b2b_data2", di0, frame(330, 10, 32));
                chk("b2b_spacing", IS'(cyc - t1), 32);
                chk("b2b_errs", {es0, en0}, 0);
            end
        end
        v0 = 1'b0;
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fc_input_packer.md
FC_INPUT_PACKER -- requirements
Module: fc_input_packer

Interface
REQ-001 Parameter INPUT_SIZE, default 512, SHALL set the packed output vector width in bits.
REQ-002 Parameter WORD_WIDTH, default 16, SHALL set the serial input sample width; INPUT_SIZE SHALL be an integer multiple of WORD_WIDTH.
REQ-003 Parameter MIN_GAP, default 4, SHALL set the number of cycles input is refused after each emission (downstream fully_connected compute time); 0 is legal.
REQ-004 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1, SHALL be the asynchronous, active-high reset.
REQ-006 Port in_data, input, WORD_WIDTH, SHALL carry one feature sample.
REQ-007 Port in_valid, input, 1, SHALL qualify in_data.
REQ-008 Port in_last, input, 1, SHALL mark the final sample of a frame and is qualified by in_valid.
REQ-009 Port in_ready, output, 1, SHALL indicate that a sample is accepted this cycle when in_valid=1.
REQ-010 Port data_in, output, INPUT_SIZE, SHALL carry the packed frame and drive the fully_connected data_in.
REQ-011 Port data_valid, output, 1, SHALL be a one-cycle strobe that qualifies data_in and drives the fully_connected data_valid.
REQ-012 Port err_short, output, 1, SHALL pulse for one cycle when a frame ends early on in_last.
REQ-013 Port err_nolast, output, 1, SHALL pulse for one cycle when a frame fills completely without in_last.

Function
REQ-014 NUM_WORDS SHALL equal INPUT_SIZE/WORD_WIDTH, and the word counter SHALL be clog2(NUM_WORDS) bits wide.
REQ-015 A transfer SHALL occur only when in_valid and in_ready are both 1.
REQ-016 Word k of a frame (k=0 first) SHALL land in slice [INPUT_SIZE-1-k*WORD_WIDTH -: WORD_WIDTH], so the first sample is the MSB slice.
REQ-017 The FSM SHALL have two states.
- FILL: in_ready=1; each transfer is stored and the counter increments.
- HOLD: in_ready=0; a gap counter counts MIN_GAP cycles, then the FSM returns to FILL.
REQ-018 A frame SHALL end on a transfer with in_last=1 or on the transfer at counter=NUM_WORDS-1, whichever comes first.
REQ-019 On frame end, data_in SHALL update and data_valid SHALL assert on the next rising edge (latency 1 cycle from the final transfer).
REQ-020 Frame end with MIN_GAP>0 SHALL enter HOLD; with MIN_GAP=0 the FSM SHALL stay in FILL, so back-to-back frames are legal.
REQ-021 On frame end, the counter SHALL clear and the assembly buffer SHALL clear to zero.
REQ-022 Early in_last (counter<NUM_WORDS-1) SHALL zero-fill unreceived slices and pulse err_short, aligned with data_valid.
REQ-023 A full frame without in_last SHALL emit normally and pulse err_nolast, aligned with data_valid.
REQ-024 in_last on word NUM_WORDS-1 SHALL be a normal frame with no error pulse.
REQ-025 data_in SHALL hold its value between strobes; assembly SHALL NOT disturb it.
REQ-026 in_valid during HOLD SHALL be ignored, with no storage and no count.

Reset
REQ-027 On reset, outputs SHALL be data_in=0, data_valid=0, in_ready=1, err_short=0, err_nolast=0.
REQ-028 On reset, the state SHALL be FILL, the counters 0 and the assembly buffer 0.
REQ-029 Reset asserted mid-frame or in HOLD SHALL discard the partial frame with no strobe.
REQ-030 The first frame after reset release SHALL start at word 0.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding and the default WORD_WIDTH/INPUT_SIZE constants shared with fully_connected.
REQ-032 No sub-module SHALL be instantiated; the gap counter and the pack datapath SHALL be inline.

Verification
REQ-033 Reset, then 32 transfers with values 1..32 and in_last on word 32 -> one data_valid strobe one cycle later; data_in = {16'd1,...,16'd32}; no error pulse.
REQ-034 MIN_GAP=4, in_valid held high -> in_ready low for exactly 4 cycles after the final transfer; the next frame captures from word 0.
REQ-035 5 transfers 10,20,30,40,50 with in_last on word 5 -> data_in upper 80 bits = {10,20,30,40,50}, lower 432 bits = 0; err_short pulses with data_valid.
REQ-036 32 transfers without in_last -> strobe emitted and err_nolast pulses; a following 32-word frame packs correctly.
REQ-037 MIN_GAP=0, frames 10..320 then 330..640 back-to-back -> two strobes 32 cycles apart, each data_in exact.
REQ-038 Reset asserted after word 17 -> no strobe and outputs at reset values; a fresh 32-word frame then packs correctly.
